// File: rtl/uart_pkg.sv
// Shared definitions for the UART AXI4-Lite command master: register offsets,
// AXI response codes, the master FSM state type and the command legality rule.
package uart_pkg;

  localparam logic [3:0] UART_REG_EN   = 4'h0;
  localparam logic [3:0] UART_REG_BAUD = 4'h4;
  localparam logic [3:0] UART_REG_DATA = 4'h8;
  localparam logic [3:0] UART_REG_STAT = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_RSP
  } state_t;

  // Misaligned offsets and writes to the read-only STATUS register are illegal
  function automatic logic offset_illegal(input logic write, input logic [3:0] offset);
    return (offset[1:0] != 2'b00) || (write && (offset == UART_REG_STAT));
  endfunction

endpackage

// File: rtl/uart_axil_master.sv
// AXI4-Lite initiator turning command requests into single-beat register
// accesses on the UART register bank, one transaction outstanding at a time.
// Optional feature: define UART_AXIL_ADDR_CHECK_EN to reject misaligned
// offsets and STATUS writes with SLVERR before any bus activity.
module uart_axil_master
  import uart_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [3:0]        cmd_offset,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  state_t            state;
  logic              aw_done;
  logic              w_done;
  logic              aw_fire;
  logic              w_fire;
  logic [ADDR_W-1:0] cmd_addr;

  assign cmd_addr = BASE_ADDR + ADDR_W'({cmd_offset[3:2], 2'b00});
  assign aw_fire  = m_awvalid && m_awready;
  assign w_fire   = m_wvalid && m_wready;
  assign m_wstrb  = 4'hF;

`ifndef UART_AXIL_ADDR_CHECK_EN
  // Low offset bits are dropped when the legality check is not built in
  logic unused_offset_lsbs;
  assign unused_offset_lsbs = ^cmd_offset[1:0];
`endif

  // Command FSM; every handshake output is a register driven from here
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      m_awaddr  <= '0;
      m_awvalid <= 1'b0;
      m_wdata   <= '0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_araddr  <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
`ifdef UART_AXIL_ADDR_CHECK_EN
            if (offset_illegal(cmd_write, cmd_offset)) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_resp  <= RESP_SLVERR;
              state     <= ST_RSP;
            end else
`endif
            if (cmd_write) begin
              m_awaddr  <= cmd_addr;
              m_wdata   <= cmd_wdata;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
              state     <= ST_WR_REQ;
            end else begin
              m_araddr  <= cmd_addr;
              m_arvalid <= 1'b1;
              state     <= ST_RD_REQ;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_WR_REQ: begin
          if (aw_fire) begin
            m_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_fire) begin
            m_wvalid <= 1'b0;
            w_done   <= 1'b1;
          end
          // Done flags cover channels that finished earlier; fire covers this cycle
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            m_bready <= 1'b1;
            state    <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (m_bvalid) begin
            m_bready  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= m_bresp;
            state     <= ST_RSP;
          end
        end
        ST_RD_REQ: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (m_rvalid) begin
            m_rready  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= m_rdata;
            rsp_resp  <= m_rresp;
            state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          cmd_ready <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_axil_master.sv
// Bench for uart_axil_master: latency-configurable AXI4-Lite slave with a
// small register bank, a handshake/stability monitor, a table of directed
// vectors, hand-written corner sequences and randomized commands checked
// against a register-level reference model.
module tb_uart_axil_master;

  localparam logic [31:0] BASE = 32'h4000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_offset = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready = 1'b0;
  logic [1:0]  m_bresp = '0;
  logic        m_bvalid = 1'b0;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic        m_rvalid = 1'b0;
  logic        m_rready;

  uart_axil_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_offset(cmd_offset), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Slave configuration for the current transaction
  int unsigned aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  logic [1:0]  resp_cfg = 2'b00;

  // Slave / monitor state
  logic [31:0] slave_regs [4] = '{32'h0, 32'h0, 32'h0, 32'h3};
  int unsigned cyc = 0;
  int unsigned aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  int unsigned aw_cyc = 0, w_cyc = 0, ar_cyc = 0;
  int unsigned proto_viol = 0, axi_valid_cyc = 0;
  logic [31:0] got_awaddr = '0, got_wdata = '0, got_araddr = '0, r_data_q = '0;
  logic [3:0]  got_wstrb = '0;
  logic        aw_seen = 1'b0, w_seen = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
  logic        aw_pq = 1'b0, w_pq = 1'b0, ar_pq = 1'b0, rsp_pq = 1'b0;
  logic [31:0] aw_q = '0, w_q = '0, ar_q = '0, rsp_dq = '0;
  logic [3:0]  ws_q = '0;
  logic [1:0]  rsp_rq = '0;

  // Reference model state
  logic [31:0] ref_regs [4] = '{32'h0, 32'h0, 32'h0, 32'h3};
  int unsigned acc_cyc = 0;

  function automatic logic [1:0] slv_idx(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return d[3:2];
  endfunction

  // Slave-side bookkeeping and protocol monitor at the active edge
  always @(posedge clk) begin
    int unsigned v;
    v = 0;
    cyc <= cyc + 1;
    if (rst) begin
      aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      aw_pq <= 1'b0; w_pq <= 1'b0; ar_pq <= 1'b0; rsp_pq <= 1'b0;
    end else begin
      if (aw_pq && (!m_awvalid || m_awaddr !== aw_q)) v++;
      if (w_pq && (!m_wvalid || m_wdata !== w_q || m_wstrb !== ws_q)) v++;
      if (ar_pq && (!m_arvalid || m_araddr !== ar_q)) v++;
      if (rsp_pq && (!rsp_valid || rsp_rdata !== rsp_dq || rsp_resp !== rsp_rq)) v++;
      if (cmd_ready && (m_awvalid || m_wvalid || m_arvalid || rsp_valid)) v++;
      proto_viol <= proto_viol + v;
      aw_pq <= m_awvalid && !m_awready; aw_q <= m_awaddr;
      w_pq <= m_wvalid && !m_wready; w_q <= m_wdata; ws_q <= m_wstrb;
      ar_pq <= m_arvalid && !m_arready; ar_q <= m_araddr;
      rsp_pq <= rsp_valid && !rsp_ready; rsp_dq <= rsp_rdata; rsp_rq <= rsp_resp;
      if (m_awvalid || m_wvalid || m_arvalid) axi_valid_cyc <= axi_valid_cyc + 1;
      if (m_awvalid && m_awready) begin
        aw_hs <= aw_hs + 1; aw_cyc <= cyc; got_awaddr <= m_awaddr; aw_seen <= 1'b1;
      end
      if (m_wvalid && m_wready) begin
        w_hs <= w_hs + 1; w_cyc <= cyc; got_wdata <= m_wdata; got_wstrb <= m_wstrb; w_seen <= 1'b1;
      end
      if (m_bvalid && m_bready) begin
        b_hs <= b_hs + 1; b_pend <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
        if (resp_cfg == 2'b00) slave_regs[slv_idx(got_awaddr)] <= got_wdata;
      end else if (!b_pend && (aw_seen || (m_awvalid && m_awready)) && (w_seen || (m_wvalid && m_wready))) begin
        b_pend <= 1'b1;
      end
      if (m_arvalid && m_arready) begin
        ar_hs <= ar_hs + 1; ar_cyc <= cyc; got_araddr <= m_araddr;
        r_data_q <= slave_regs[slv_idx(m_araddr)]; r_pend <= 1'b1;
      end
      if (m_rvalid && m_rready) begin
        r_hs <= r_hs + 1; r_pend <= 1'b0;
      end
    end
  end

  // Slave drive on the falling edge, wait states counted per channel
  int unsigned aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  always @(negedge clk) begin
    if (rst) begin
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
    end else begin
      if (m_awvalid) begin m_awready = (aw_wait >= aw_lat); aw_wait++; end
      else begin m_awready = 1'b0; aw_wait = 0; end
      if (m_wvalid) begin m_wready = (w_wait >= w_lat); w_wait++; end
      else begin m_wready = 1'b0; w_wait = 0; end
      if (m_arvalid) begin m_arready = (ar_wait >= ar_lat); ar_wait++; end
      else begin m_arready = 1'b0; ar_wait = 0; end
      if (b_pend) begin m_bvalid = (b_wait >= b_lat); m_bresp = resp_cfg; b_wait++; end
      else begin m_bvalid = 1'b0; b_wait = 0; end
      if (r_pend) begin m_rvalid = (r_wait >= r_lat); m_rdata = r_data_q; m_rresp = resp_cfg; r_wait++; end
      else begin m_rvalid = 1'b0; r_wait = 0; end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one command, wait for its response, hold rsp_ready low for 'hold' cycles
  task automatic do_cmd(input logic wr, input logic [3:0] off, input logic [31:0] wd,
                        input int unsigned hold,
                        output logic [31:0] rd, output logic [1:0] rs, output int unsigned ed);
    int unsigned n;
    int unsigned unstable;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("cmd_ready_before_accept", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_offset = off; cmd_wdata = wd;
    acc_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_offset = 4'($urandom); cmd_wdata = $urandom;
    ed = 1;
    while (!rsp_valid && ed < 100) begin @(posedge clk); #1; ed++; end
    check("rsp_valid_seen", rsp_valid, 1);
    rd = rsp_rdata; rs = rsp_resp;
    unstable = 0;
    for (int i = 0; i < int'(hold); i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_resp !== rs || cmd_ready !== 1'b0) unstable++;
    end
    if (hold > 0) check("rsp_hold_stable", unstable, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_release_idle", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  task automatic set_slave(input int unsigned awl, wl, bl, arl, rl, input logic [1:0] resp);
    aw_lat = awl; w_lat = wl; b_lat = bl; ar_lat = arl; r_lat = rl; resp_cfg = resp;
  endtask

  // Register-level expectation: legality, response code, data and latency
  task automatic ref_apply(input logic wr, input logic [3:0] off, input logic [31:0] wd,
                           input logic [1:0] resp, input int unsigned awl, wl, bl, arl, rl,
                           output logic [31:0] erd, output logic [1:0] ers,
                           output int unsigned eed, output logic legal);
    int unsigned idx;
    idx = off / 4;
    legal = 1'b1;
`ifdef UART_AXIL_ADDR_CHECK_EN
    legal = (off % 4 == 0) && !(wr && off == 4'd12);
`endif
    if (!legal) begin
      erd = 0; ers = 2'b10; eed = 1;
    end else if (wr) begin
      erd = 0; ers = resp; eed = 3 + ((awl > wl) ? awl : wl) + bl;
      if (resp == 2'b00) ref_regs[idx] = wd;
    end else begin
      erd = ref_regs[idx]; ers = resp; eed = 3 + arl + rl;
    end
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  off;
    logic [31:0] wd;
    int unsigned awl, wl, bl, arl, rl;
    logic [1:0]  resp;
    int unsigned hold;
    logic [31:0] exp_rd;
    logic [1:0]  exp_rs;
    int unsigned exp_ed;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, erd;
    logic [1:0]  rs, ers;
    int unsigned ed, eed;
    logic        legal;
    int unsigned b0, aw0, w0, ar0, v0;

    tbl[0] = '{1'b1, 4'h0, 32'h0000_0001, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 2'b00, 3};
    tbl[1] = '{1'b1, 4'h8, 32'h0000_00A5, 2, 0, 1, 0, 0, 2'b00, 0, 32'h0, 2'b00, 6};
    tbl[2] = '{1'b0, 4'h0, 32'h0,         0, 0, 0, 0, 0, 2'b00, 0, 32'h1, 2'b00, 3};
`ifdef UART_AXIL_ADDR_CHECK_EN
    tbl[3] = '{1'b0, 4'h9, 32'h0,         0, 0, 0, 1, 1, 2'b00, 0, 32'h0, 2'b10, 1};
`else
    tbl[3] = '{1'b0, 4'h9, 32'h0,         0, 0, 0, 1, 1, 2'b00, 0, 32'hA5, 2'b00, 5};
`endif
    tbl[4] = '{1'b1, 4'h4, 32'hDEAD_BEEF, 1, 3, 0, 0, 0, 2'b11, 0, 32'h0, 2'b11, 6};
    tbl[5] = '{1'b0, 4'h4, 32'h0,         0, 0, 0, 0, 0, 2'b10, 1, 32'h1B2, 2'b10, 3};
    tbl[6] = '{1'b0, 4'hC, 32'h0,         0, 0, 0, 0, 0, 2'b00, 3, 32'h3, 2'b00, 3};
`ifdef UART_AXIL_ADDR_CHECK_EN
    tbl[7] = '{1'b1, 4'hC, 32'h0000_0077, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 2'b10, 1};
    tbl[8] = '{1'b0, 4'hC, 32'h0,         0, 0, 0, 0, 0, 2'b00, 0, 32'h3, 2'b00, 3};
`else
    tbl[7] = '{1'b1, 4'hC, 32'h0000_0077, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 2'b00, 3};
    tbl[8] = '{1'b0, 4'hC, 32'h0,         0, 0, 0, 0, 0, 2'b00, 0, 32'h77, 2'b00, 3};
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_valids_readies", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid, cmd_ready}, 0);
    check("reset_rsp_payload", {rsp_rdata, rsp_resp}, 0);
    check("reset_addresses", {m_awaddr, m_araddr}, 0);
    check("reset_wdata", m_wdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("cmd_ready_after_reset", cmd_ready, 1);

    // Write BAUD with a zero-wait slave
    set_slave(0, 0, 0, 0, 0, 2'b00);
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    do_cmd(1'b1, 4'h4, 32'h0000_01B2, 0, rd, rs, ed);
    ref_apply(1'b1, 4'h4, 32'h0000_01B2, 2'b00, 0, 0, 0, 0, 0, erd, ers, eed, legal);
    check("baud_awaddr", got_awaddr, BASE + 32'h4);
    check("baud_wdata", got_wdata, 32'h1B2);
    check("baud_wstrb", got_wstrb, 4'hF);
    check("baud_latency", ed, 3);
    check("baud_resp", {rs, rd}, 0);
    check("baud_handshakes", {aw_hs - aw0, w_hs - w0, b_hs - b0}, {32'd1, 32'd1, 32'd1});

    // W completes at cycle 1, AW held until cycle 4
    set_slave(3, 0, 0, 0, 0, 2'b00);
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    do_cmd(1'b1, 4'h0, 32'h0000_0055, 0, rd, rs, ed);
    ref_apply(1'b1, 4'h0, 32'h0000_0055, 2'b00, 3, 0, 0, 0, 0, erd, ers, eed, legal);
    check("w_first_w_cycle", w_cyc - acc_cyc, 1);
    check("w_first_aw_cycle", aw_cyc - acc_cyc, 4);
    check("w_first_handshakes", {aw_hs - aw0, w_hs - w0, b_hs - b0}, {32'd1, 32'd1, 32'd1});
    check("w_first_awaddr", got_awaddr, BASE);
    check("w_first_latency", ed, 6);

    // Read STATUS with wait states on AR and R
    set_slave(0, 0, 0, 2, 2, 2'b00);
    ar0 = ar_hs;
    do_cmd(1'b0, 4'hC, 32'h0, 0, rd, rs, ed);
    ref_apply(1'b0, 4'hC, 32'h0, 2'b00, 0, 0, 0, 2, 2, erd, ers, eed, legal);
    check("status_rdata", rd, 32'h3);
    check("status_resp", rs, 2'b00);
    check("status_ar_cycle", ar_cyc - acc_cyc, 3);
    check("status_araddr", got_araddr, BASE + 32'hC);
    check("status_latency", ed, 7);
    check("status_ar_count", ar_hs - ar0, 1);

    // SLVERR read held under response back-pressure
    set_slave(0, 0, 0, 0, 0, 2'b10);
    do_cmd(1'b0, 4'h8, 32'h0, 5, rd, rs, ed);
    ref_apply(1'b0, 4'h8, 32'h0, 2'b10, 0, 0, 0, 0, 0, erd, ers, eed, legal);
    check("bp_resp", rs, 2'b10);
    check("bp_rdata", rd, erd);

    // Reset while a write is waiting on AW and W
    set_slave(10, 10, 0, 0, 0, 2'b00);
    check("mid_rst_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_offset = 4'h8; cmd_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_awvalid_pending", {m_awvalid, m_wvalid}, 2'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valids_cleared", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid, cmd_ready}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_cmd_ready", cmd_ready, 1);
    set_slave(0, 0, 0, 0, 0, 2'b00);
    do_cmd(1'b0, 4'h8, 32'h0, 0, rd, rs, ed);
    ref_apply(1'b0, 4'h8, 32'h0, 2'b00, 0, 0, 0, 0, 0, erd, ers, eed, legal);
    check("post_rst_read", {rd, rs}, {erd, ers});
    check("post_rst_latency", ed, 3);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      set_slave(tbl[i].awl, tbl[i].wl, tbl[i].bl, tbl[i].arl, tbl[i].rl, tbl[i].resp);
      do_cmd(tbl[i].wr, tbl[i].off, tbl[i].wd, tbl[i].hold, rd, rs, ed);
      ref_apply(tbl[i].wr, tbl[i].off, tbl[i].wd, tbl[i].resp, tbl[i].awl, tbl[i].wl,
                tbl[i].bl, tbl[i].arl, tbl[i].rl, erd, ers, eed, legal);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_resp", i), rs, tbl[i].exp_rs);
      check($sformatf("tbl%0d_latency", i), ed, tbl[i].exp_ed);
    end

`ifdef UART_AXIL_ADDR_CHECK_EN
    // Illegal commands never reach the bus
    set_slave(0, 0, 0, 0, 0, 2'b00);
    v0 = axi_valid_cyc;
    do_cmd(1'b1, 4'hC, 32'hFFFF_FFFF, 0, rd, rs, ed);
    check("chk_stat_write_resp", {rd, rs}, {32'h0, 2'b10});
    check("chk_stat_write_latency", ed, 1);
    do_cmd(1'b0, 4'h5, 32'h0, 0, rd, rs, ed);
    check("chk_misaligned_resp", {rd, rs}, {32'h0, 2'b10});
    check("chk_misaligned_latency", ed, 1);
    check("chk_no_axi_valid", axi_valid_cyc - v0, 0);
`endif

    // Randomized commands against the reference model
    for (int i = 0; i < 40; i++) begin
      logic        wr;
      logic [3:0]  off;
      logic [31:0] wd;
      logic [1:0]  resp;
      int unsigned awl, wl, bl, arl, rl, hold, sel;
      wr = 1'($urandom); off = 4'($urandom); wd = $urandom;
      awl = $urandom_range(3, 0); wl = $urandom_range(3, 0); bl = $urandom_range(2, 0);
      arl = $urandom_range(3, 0); rl = $urandom_range(2, 0); hold = $urandom_range(2, 0);
      sel = $urandom_range(4, 0);
      resp = (sel == 3) ? 2'b10 : (sel == 4) ? 2'b11 : 2'b00;
      set_slave(awl, wl, bl, arl, rl, resp);
      aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs; b0 = b_hs;
      do_cmd(wr, off, wd, hold, rd, rs, ed);
      ref_apply(wr, off, wd, resp, awl, wl, bl, arl, rl, erd, ers, eed, legal);
      check($sformatf("rnd%0d_rdata", i), rd, erd);
      check($sformatf("rnd%0d_resp", i), rs, ers);
      check($sformatf("rnd%0d_latency", i), ed, eed);
      check($sformatf("rnd%0d_hs_counts", i), {aw_hs - aw0, w_hs - w0, b_hs - b0, ar_hs - ar0},
            {32'(legal && wr), 32'(legal && wr), 32'(legal && wr), 32'(legal && !wr)});
      if (legal && wr)
        check($sformatf("rnd%0d_wr_bus", i), {got_awaddr, got_wdata}, {BASE + 32'(off & 4'hC), wd});
      if (legal && !wr)
        check($sformatf("rnd%0d_araddr", i), got_araddr, BASE + 32'(off & 4'hC));
    end

    check("protocol_violations", proto_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
